sklansky_accum_16: RTL and testbench
====================================

Name: sklansky_accum_16

Overview:
- Sequential multi-operand accumulator sitting directly downstream of the team's 16-bit Sklansky prefix adder.
- Accepts a stream of 16-bit operands over a valid/ready handshake and sums a programmed number of them.
- Uses one adder instance as its combinational core, with the accumulator register fed back as operand a and cin tied to 0.
- Emits the final sum and an overflow (carry-out) count over an output valid/ready handshake.

Parameters:
- WIDTH, 16, operand/accumulator width; must match the adder core.
- CNT_W, 8, width of the length and carry-count fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  CNT_W  number of operands to accumulate; captured when start is accepted.
- in_valid  input  1  operand available.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  accumulated sum, modulo 2^WIDTH.
- out_carries  output  CNT_W  count of adder carry-outs during the run; saturates at all-ones.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, acc=0, remaining=0, carries=0; in_ready=0, out_valid=0, out_sum=0, out_carries=0, busy=0.
- State machine: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: capture remaining=len, clear acc and carries, go to ACCUM.
  - start=1 and len=0: clear acc and carries, go directly to DONE.
- ACCUM:
  - in_ready=1.
  - Each beat with in_valid && in_ready: acc <= sum from adder(a=acc, b=in_data, cin=0).
  - On the same beat, if cout=1, carries increments, saturating at 2^CNT_W-1.
  - remaining decrements on each beat; the beat that brings it to 0 moves the state to DONE.
  - in_valid=0 cycles: no change.
- DONE:
  - out_valid=1; out_sum=acc and out_carries=carries, both held stable while out_valid && !out_ready.
  - When out_valid && out_ready: go to IDLE, out_valid drops next cycle.
- Latency: out_valid rises the cycle after the last operand is accepted. For len=0, out_valid rises the cycle after start.
- start in ACCUM or DONE is ignored; len is not re-sampled.
- in_ready is 0 in IDLE and DONE, so no operand is consumed there.
- out_sum and out_carries retain the last result in IDLE until the next start.
- Reset asserted mid-run discards the partial sum and returns all outputs to their reset values immediately.
- Arithmetic wraps modulo 2^WIDTH; overflow is reported only through out_carries.
- The adder is purely combinational. acc is the only registered datapath; there is no internal pipelining.

Decomposition:
- Shared package sklansky_pkg holds:
  - state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - WIDTH_DEF=16 and CNT_W_DEF=8 constants.
- One sub-module: the existing 16-bit adder, module sklansky, instanced once as the combinational core with cin tied to 1'b0. No other sub-modules.

Test Plan:
- Basic sum: start with len=2; send 15 then 8 back-to-back -> one cycle after the second beat, out_valid=1, out_sum=23, out_carries=0.
- Overflow: len=3; operands 32768, 32767, 1 -> out_sum=0, out_carries=1.
- Multi-overflow with gaps: len=4; operands 40000, 40000, 40000, 40000 with in_valid deasserted 2 cycles between beats -> out_sum=28928, out_carries=2; in_ready stays high throughout ACCUM.
- Zero length and backpressure:
  - len=0 -> out_valid the cycle after start, out_sum=0, out_carries=0.
  - Hold out_ready=0 for 5 cycles and pulse start with len=7 during the stall -> outputs stable, start ignored, block returns to IDLE only after out_ready=1.
- Reset mid-run: len=3, accept 5158 and 25000, then pulse rst_n low -> all outputs 0, busy=0 immediately.
  - Then len=2 with operands 2768 and 30000 -> out_sum=32768, out_carries=0.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared types and constants for the Sklansky adder and the accumulator built on it.
// Holds the accumulator state encoding and the default datapath widths.
package sklansky_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sklansky.sv
// Purely combinational Sklansky (divide-and-conquer) parallel-prefix adder.
// sum/cout = a + b + cin.
module sklansky
    import sklansky_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // At level l, every bit with bit l of its index set absorbs the group
    // ending just below its aligned 2^l block.
    function automatic logic [WIDTH:0] prefix_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             c0);
        logic [WIDTH-1:0] g, p, g_n, p_n, p_bit;
        logic [WIDTH:0]   c;
        int               j;
        g     = x & y;
        p     = x ^ y;
        p_bit = p;
        for (int l = 0; l < int'(LEVELS); l++) begin
            g_n = g;
            p_n = p;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (((i >> l) & 1) == 1) begin
                    j      = ((i >> l) << l) - 1;
                    g_n[i] = g[i] | (p[i] & g[j]);
                    p_n[i] = p[i] & p[j];
                end
            end
            g = g_n;
            p = p_n;
        end
        c[0] = c0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c[i+1] = g[i] | (p[i] & c0);
        end
        return {c[WIDTH], p_bit ^ c[WIDTH-1:0]};
    endfunction

    assign {cout, sum} = prefix_add(a, b, cin);

endmodule

// File: rtl/sklansky_accum_16.sv
// Multi-operand accumulator: sums a programmed number of streamed operands through
// one Sklansky adder and reports the wrapped sum plus a saturating carry-out count.
module sklansky_accum_16
    import sklansky_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] carries_q, carries_d;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    sklansky #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            carries_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            carries_q <= carries_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        carries_d = carries_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    carries_d = '0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    if (add_cout && (carries_q != '1)) begin
                        carries_d = carries_q + 1'b1;
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers double as output holding registers across IDLE.
    assign out_sum     = acc_q;
    assign out_carries = carries_q;

endmodule

// File: tb/tb_sklansky_accum_16.sv
// Directed bench for sklansky_accum_16: expected results go into a queue on issue and a
// monitor pops and compares them on every output handshake.
module tb_sklansky_accum_16;

    typedef struct packed {
        logic [15:0] sum;
        logic [7:0]  carries;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_carries;
    logic        busy;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    sklansky_accum_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carries(out_carries),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is visible at the negedge before the accepting posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_carries", 32'(out_carries), 32'(e.carries));
            end
        end
    end

    task automatic start_run(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk("in_ready_accum", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'd0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 16'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_carries", 32'(out_carries), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic sum, back-to-back operands, one-cycle result latency.
        exp_q.push_back('{sum: 16'd23, carries: 8'd0});
        start_run(8'd2);
        send(16'd15);
        send(16'd8);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_retain_sum", 32'(out_sum), 32'd23);
        @(posedge clk);
        #1;

        // Single overflow.
        exp_q.push_back('{sum: 16'd0, carries: 8'd1});
        start_run(8'd3);
        send(16'd32768);
        send(16'd32767);
        send(16'd1);
        wait_out();

        // Two overflows with two idle cycles between beats.
        exp_q.push_back('{sum: 16'd28928, carries: 8'd2});
        start_run(8'd4);
        for (int k = 0; k < 4; k++) begin
            send(16'd40000);
            if (k < 3) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("in_ready_gap", 32'(in_ready), 32'd1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_out();

        // Zero length goes straight to DONE.
        exp_q.push_back('{sum: 16'd0, carries: 8'd0});
        start_run(8'd0);
        @(negedge clk);
        chk("len0_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure with an ignored start during the stall.
        exp_q.push_back('{sum: 16'd1234, carries: 8'd0});
        out_ready = 1'b0;
        start_run(8'd1);
        send(16'd1234);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1;
                len   = 8'd7;
            end
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_sum", 32'(out_sum), 32'd1234);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            len   = 8'd0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_stall_out_valid", 32'(out_valid), 32'd0);
        chk("post_stall_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-run discards the partial sum immediately.
        start_run(8'd3);
        send(16'd5158);
        send(16'd25000);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_sum", 32'(out_sum), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        exp_q.push_back('{sum: 16'd32768, carries: 8'd0});
        start_run(8'd2);
        send(16'd2768);
        send(16'd30000);
        wait_out();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
